// File: rtl/multiplicador_seq_if.sv
// rtl/multiplicador_seq_if.sv - start/operand/result bundle for the sequential multiplier
interface multiplicador_seq_if #(
  parameter int WIDTH = 16
);
  logic                 St;
  logic                 Signed;
  logic [WIDTH-1:0]     Multiplicando;
  logic [WIDTH-1:0]     Multiplicador;
  logic [2*WIDTH-1:0]   Produto;
  logic                 Busy;
  logic                 Done;

  modport master (
    output St, Signed, Multiplicando, Multiplicador,
    input  Produto, Busy, Done
  );

  modport slave (
    input  St, Signed, Multiplicando, Multiplicador,
    output Produto, Busy, Done
  );
endinterface

// File: rtl/multiplicador_seq.sv
// rtl/multiplicador_seq.sv - sequential shift-add / radix-2 Booth multiplier, one bit per cycle
module multiplicador_seq #(
  parameter int WIDTH = 16
) (
  input logic               Clk,
  input logic               Reset,
  multiplicador_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 sgn_q, sgn_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // Upper half is the accumulator, lower half starts as the multiplier and
  // fills with product bits as it shifts out.
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  // Booth's implicit bit to the right of the multiplier LSB.
  logic                 qm1_q, qm1_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       acc_ext;
  logic [WIDTH:0]       mcand_ext;
  logic [WIDTH:0]       sum;

  // Partial-sum adder (one bit wider than the operands) and next-state logic.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    qm1_d   = qm1_q;
    busy_d  = busy_q;
    done_d  = done_q;

    acc_ext   = sgn_q ? {prod_q[2*WIDTH-1], prod_q[2*WIDTH-1:WIDTH]}
                      : {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    mcand_ext = sgn_q ? {mcand_q[WIDTH-1], mcand_q} : {1'b0, mcand_q};
    sum       = acc_ext;
    if (sgn_q) begin
      case ({prod_q[0], qm1_q})
        2'b01:   sum = acc_ext + mcand_ext;
        2'b10:   sum = acc_ext - mcand_ext;
        default: sum = acc_ext;
      endcase
    end else if (prod_q[0]) begin
      sum = acc_ext + mcand_ext;
    end

    case (state_q)
      IDLE: begin
        if (bus.St) begin
          mcand_d = bus.Multiplicando;
          sgn_d   = bus.Signed;
          prod_d  = {{WIDTH{1'b0}}, bus.Multiplicador};
          qm1_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        // The extra sum bit carries the unsigned carry-out or the Booth sign,
        // so shifting it in gives the right (arithmetic) shift in both modes.
        prod_d = {sum, prod_q[WIDTH-1:1]};
        qm1_d  = prod_q[0];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      qm1_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      qm1_q   <= qm1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Produto = prod_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;

endmodule

// File: tb/tb_multiplicador_seq.sv
// tb/tb_multiplicador_seq.sv - scoreboard bench for multiplicador_seq at WIDTH 16 and 8
module tb_multiplicador_seq;

  logic Clk = 1'b0;
  logic rst16 = 1'b1;
  logic rst8 = 1'b1;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done16_cnt = 0;
  int done8_cnt = 0;

  logic [31:0] exp16[$];
  logic [15:0] exp8[$];

  multiplicador_seq_if #(.WIDTH(16)) if16 ();
  multiplicador_seq_if #(.WIDTH(8))  if8 ();

  multiplicador_seq #(.WIDTH(16)) u16 (.Clk(Clk), .Reset(rst16), .bus(if16));
  multiplicador_seq #(.WIDTH(8))  u8  (.Clk(Clk), .Reset(rst8),  .bus(if8));

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitors: every Done pulse pops one expected product.
  always @(negedge Clk) begin
    if (if16.Done === 1'b1) begin
      done16_cnt++;
      if (exp16.size() == 0) check("done16_unexpected", 64'(1), 64'(0));
      else check("prod16", 64'(if16.Produto), 64'(exp16.pop_front()));
    end
  end

  always @(negedge Clk) begin
    if (if8.Done === 1'b1) begin
      done8_cnt++;
      if (exp8.size() == 0) check("done8_unexpected", 64'(1), 64'(0));
      else check("prod8", 64'(if8.Produto), 64'(exp8.pop_front()));
    end
  end

  task automatic op16(input logic s, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] exp, input string name);
    int lat;
    int busy_n;
    @(negedge Clk);
    if16.St = 1'b1; if16.Signed = s; if16.Multiplicando = a; if16.Multiplicador = b;
    exp16.push_back(exp);
    @(posedge Clk); #1;
    if16.St = 1'b0;
    lat = 0;
    busy_n = (if16.Busy === 1'b1) ? 1 : 0;
    while (if16.Done !== 1'b1 && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
      if (if16.Busy === 1'b1) busy_n++;
    end
    check({name, "_latency"}, 64'(lat), 64'(16));
    @(posedge Clk); #1;
    check({name, "_busy_cycles"}, 64'(busy_n), 64'(17));
    check({name, "_idle_busy"}, 64'(if16.Busy), 64'(0));
    repeat (3) @(negedge Clk);
    check({name, "_hold"}, 64'(if16.Produto), 64'(exp));
  endtask

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input string name);
    int lat;
    @(negedge Clk);
    if8.St = 1'b1; if8.Signed = s; if8.Multiplicando = a; if8.Multiplicador = b;
    exp8.push_back(exp);
    @(posedge Clk); #1;
    if8.St = 1'b0;
    lat = 0;
    while (if8.Done !== 1'b1 && lat < 30) begin
      @(posedge Clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(8));
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    int d0;
    int t[3];
    int n;
    int cyc;
    if16.St = 0; if16.Signed = 0; if16.Multiplicando = 0; if16.Multiplicador = 0;
    if8.St = 0;  if8.Signed = 0;  if8.Multiplicando = 0;  if8.Multiplicador = 0;
    #1;
    check("reset_prod16", 64'(if16.Produto), 64'(0));
    check("reset_busy16", 64'(if16.Busy), 64'(0));
    check("reset_done16", 64'(if16.Done), 64'(0));
    check("reset_prod8", 64'(if8.Produto), 64'(0));
    repeat (2) @(negedge Clk);
    rst16 = 1'b0; rst8 = 1'b0;

    op16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "u_ffff");
    op16(1'b1, 16'h8000, 16'h8000, 32'h40000000, "s_min_min");
    op16(1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, "s_m1_m1");
    op16(1'b1, 16'hFFFD, 16'd5,    32'hFFFFFFF1, "s_m3_5");
    op16(1'b0, 16'd0,    16'h1234, 32'h00000000, "u_zero");

    op8(1'b1, 8'h80, 8'h7F, 16'hC080, "s8_min_max");
    op8(1'b0, 8'h80, 8'h7F, 16'h3F80, "u8_80_7f");
    op8(1'b1, 8'h80, 8'h80, 16'h4000, "s8_min_min");
    op8(1'b1, 8'h00, 8'h80, 16'h0000, "s8_zero");

    // St re-pulsed and inputs changed while calculating.
    d0 = done16_cnt;
    @(negedge Clk);
    if16.St = 1'b1; if16.Signed = 1'b0; if16.Multiplicando = 16'd1234; if16.Multiplicador = 16'd5678;
    exp16.push_back(32'd7006652);
    @(negedge Clk);
    if16.St = 1'b0;
    repeat (2) @(negedge Clk);
    if16.St = 1'b1; if16.Signed = 1'b1; if16.Multiplicando = 16'hFFFF; if16.Multiplicador = 16'h8000;
    repeat (4) @(negedge Clk);
    if16.St = 1'b0;
    repeat (20) @(negedge Clk);
    check("midcalc_done_count", 64'(done16_cnt - d0), 64'(1));

    // Reset at CALC cycle 5 aborts without a Done pulse.
    d0 = done16_cnt;
    @(negedge Clk);
    if16.St = 1'b1; if16.Signed = 1'b0; if16.Multiplicando = 16'd100; if16.Multiplicador = 16'd200;
    @(negedge Clk);
    if16.St = 1'b0;
    repeat (5) @(posedge Clk);
    #2 rst16 = 1'b1;
    #1;
    check("abort_prod", 64'(if16.Produto), 64'(0));
    check("abort_busy", 64'(if16.Busy), 64'(0));
    check("abort_done", 64'(if16.Done), 64'(0));
    repeat (2) @(negedge Clk);
    rst16 = 1'b0;
    repeat (25) @(negedge Clk);
    check("abort_no_done", 64'(done16_cnt - d0), 64'(0));
    op16(1'b0, 16'd300, 16'd7, 32'd2100, "after_reset");

    // St held high: three back-to-back results.
    @(negedge Clk);
    if16.St = 1'b1; if16.Signed = 1'b0; if16.Multiplicando = 16'd3; if16.Multiplicador = 16'd5;
    repeat (3) exp16.push_back(32'd15);
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 100) begin
      @(posedge Clk); #1;
      cyc++;
      if (if16.Done === 1'b1) begin
        t[n] = cyc;
        n++;
      end
    end
    if16.St = 1'b0;
    check("b2b_count", 64'(n), 64'(3));
    if (n == 3) begin
      check("b2b_gap1", 64'(t[1] - t[0]), 64'(18));
      check("b2b_gap2", 64'(t[2] - t[1]), 64'(18));
    end
    repeat (25) @(negedge Clk);
    check("exp16_drained", 64'(exp16.size()), 64'(0));
    check("exp8_drained", 64'(exp8.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
